// File: rtl/riscv_dmem_ctrl.sv
// Single-port data memory with req/ack handshake, byte-masked writes and range checking.
// Define DMEM_MISALIGN_CHK_EN to also flag misaligned addresses and irregular write masks.
module riscv_dmem_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              dmreq_in,
  input  logic              dmwe_in,
  input  logic [ADDR_W-1:0] dmaddr_in,
  input  logic [3:0]        dmwr_mask_in,
  input  logic [31:0]       dmdata_in,
  output logic              dmready_out,
  output logic              dmack_out,
  output logic [31:0]       dmdata_out,
  output logic              dmerr_out
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [0:DEPTH_WORDS-1];

  logic              accept, enter_resp, commit;
  logic              c_we, c_oor, c_err;
  logic [ADDR_W-1:0] c_addr;
  logic [3:0]        c_mask;
  logic [31:0]       c_wdata, c_bmask;
  logic [IDX_W-1:0]  c_idx;

  assign dmready_out = (state == S_IDLE);
  assign accept      = (state == S_IDLE) && dmreq_in;
  assign enter_resp  = (accept && (WAIT_STATES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));
  assign commit      = enter_resp && rst_in;

  // With no wait states the commit edge is the accept edge, so use the live request.
  assign c_we    = (state == S_IDLE) ? dmwe_in      : we_q;
  assign c_addr  = (state == S_IDLE) ? dmaddr_in    : addr_q;
  assign c_mask  = (state == S_IDLE) ? dmwr_mask_in : mask_q;
  assign c_wdata = (state == S_IDLE) ? dmdata_in    : wdata_q;
  assign c_idx   = c_addr[IDX_W+1:2];
  assign c_oor   = |c_addr[ADDR_W-1:IDX_W+2];
  assign c_bmask = {{8{c_mask[3]}}, {8{c_mask[2]}}, {8{c_mask[1]}}, {8{c_mask[0]}}};

`ifdef DMEM_MISALIGN_CHK_EN
  logic mask_ok;

  always_comb begin
    mask_ok = 1'b0;
    case (c_mask)
      4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0: mask_ok = 1'b1;
      default:                                        mask_ok = 1'b0;
    endcase
  end

  // The mask is irrelevant to reads, so only writes are checked for mask shape.
  assign c_err = c_oor || (c_addr[1:0] != 2'b00) || (c_we && !mask_ok);
`else
  logic [1:0] unused_lsb;
  assign unused_lsb = c_addr[1:0];
  assign c_err      = c_oor;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (dmreq_in) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      mask_q     <= 4'd0;
      wdata_q    <= 32'd0;
      dmack_out  <= 1'b0;
      dmerr_out  <= 1'b0;
      dmdata_out <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= dmwe_in;
        addr_q  <= dmaddr_in;
        mask_q  <= dmwr_mask_in;
        wdata_q <= dmdata_in;
      end
      dmack_out  <= enter_resp;
      dmerr_out  <= enter_resp && c_err;
      dmdata_out <= (enter_resp && !c_we && !c_err) ? mem[c_idx] : 32'd0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (commit && c_we && !c_err)
      mem[c_idx] <= (mem[c_idx] & ~c_bmask) | (c_wdata & c_bmask);
  end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Self-checking bench for riscv_dmem_ctrl: two instances (0 and 3 wait states) against a word-array model.
module tb_riscv_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [3:0]  mask  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int          ws_of [2] = '{0, 3};
  logic [31:0] model [2][64];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
    .clk_in(clk), .rst_in(rst_n[0]), .dmreq_in(req[0]), .dmwe_in(we[0]),
    .dmaddr_in(addr[0]), .dmwr_mask_in(mask[0]), .dmdata_in(wdata[0]),
    .dmready_out(ready[0]), .dmack_out(ack[0]), .dmdata_out(rdata[0]), .dmerr_out(err[0]));

  riscv_dmem_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_STATES(3)) u_dut3 (
    .clk_in(clk), .rst_in(rst_n[1]), .dmreq_in(req[1]), .dmwe_in(we[1]),
    .dmaddr_in(addr[1]), .dmwr_mask_in(mask[1]), .dmdata_in(wdata[1]),
    .dmready_out(ready[1]), .dmack_out(ack[1]), .dmdata_out(rdata[1]), .dmerr_out(err[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic check_reset_outputs(input int u, input string tag);
    check({tag, "_ready"}, 32'(ready[u]), 32'd1);
    check({tag, "_ack"},   32'(ack[u]),   32'd0);
    check({tag, "_err"},   32'(err[u]),   32'd0);
    check({tag, "_data"},  rdata[u],      32'd0);
  endtask

  // One full access; checks latency, busy window, error, read data and the idle cycle after.
  task automatic access(input int u, input logic w, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, input string tag);
    int          n;
    bit          busy_ok;
    logic        exp_err;
    logic [31:0] exp_data;
    int          idx;
    exp_err  = (a >= 32'd256);
    idx      = int'(a[7:2]);
    exp_data = (w || exp_err) ? 32'd0 : model[u][idx];
    @(negedge clk);
    req[u] = 1'b1; we[u] = w; addr[u] = a; mask[u] = m; wdata[u] = d;
    n = 0;
    while (!ready[u] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req[u] = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!ack[u] && n < 50) begin
      if (ready[u]) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (ready[u]) busy_ok = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(1 + ws_of[u]));
    check({tag, "_busy"},    32'(busy_ok), 32'd1);
    check({tag, "_err"},     32'(err[u]), 32'(exp_err));
    check({tag, "_rdata"},   rdata[u], exp_data);
    if (w && !exp_err) model[u][idx] = merge(model[u][idx], d, m);
    @(negedge clk);
    check({tag, "_idle_ack"},  32'(ack[u]), 32'd0);
    check({tag, "_idle_data"}, rdata[u],    32'd0);
  endtask

  initial begin
    int          n;
    bit          ok;
    logic [31:0] a;
    logic [31:0] d;
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; req[u] = 1'b0; we[u] = 1'b0;
      addr[u] = 32'd0; mask[u] = 4'd0; wdata[u] = 32'd0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "reset0");
    check_reset_outputs(1, "reset3");
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    for (int i = 0; i < 64; i++) begin
      access(0, 1'b1, 32'(i * 4), 4'hF, $urandom, "preload0");
      access(1, 1'b1, 32'(i * 4), 4'hF, $urandom, "preload3");
    end

    access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "word_wr");
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, "word_rd");
    check("word_rd_model", model[0][4], 32'hDEADBEEF);

    access(0, 1'b1, 32'h20, 4'hF, 32'h11223344, "merge_pre");
    access(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, "merge_wr");
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, "merge_rd");
    check("merge_model", model[0][8], 32'h11BB33DD);

    access(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, "mask0_wr");
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, "mask0_rd");

    access(0, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D, "oor_wr");
    access(0, 1'b0, 32'h0, 4'hF, 32'h0, "oor_word0");
    access(0, 1'b0, 32'h100, 4'hF, 32'h0, "oor_rd");
    access(0, 1'b0, 32'h8000_0000, 4'hF, 32'h0, "oor_msb_rd");

    access(0, 1'b1, 32'h6, 4'hF, 32'h600DCAFE, "misalign_wr");
    access(0, 1'b0, 32'h4, 4'hF, 32'h0, "misalign_rd");
    check("misalign_model", model[0][1], 32'h600DCAFE);

    access(1, 1'b1, 32'h40, 4'hF, 32'h12345678, "ws3_wr");
    access(1, 1'b0, 32'h40, 4'hF, 32'h0, "ws3_rd");

    // A request held through the busy window is taken the cycle after the ack.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h44; mask[1] = 4'hF; wdata[1] = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    addr[1] = 32'h48; wdata[1] = 32'h5A5A5A5A;
    n = 1;
    while (!ack[1] && n < 50) begin @(negedge clk); n++; end
    check("hold_first_latency", 32'(n), 32'd4);
    model[1][17] = 32'hA5A5A5A5;
    @(negedge clk);
    check("hold_ready_after_ack", 32'(ready[1]), 32'd1);
    @(negedge clk);
    req[1] = 1'b0;
    check("hold_accepted", 32'(ready[1]), 32'd0);
    n = 1;
    while (!ack[1] && n < 50) begin @(negedge clk); n++; end
    check("hold_second_latency", 32'(n), 32'd4);
    model[1][18] = 32'h5A5A5A5A;
    access(1, 1'b0, 32'h44, 4'hF, 32'h0, "hold_rd_a");
    access(1, 1'b0, 32'h48, 4'hF, 32'h0, "hold_rd_b");

    access(1, 1'b1, 32'h8, 4'hF, 32'h0, "rst_pre");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; mask[1] = 4'hF; wdata[1] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    @(posedge clk);
    #2 rst_n[1] = 1'b0;
    #1 check_reset_outputs(1, "rst_mid");
    ok = 1'b1;
    repeat (4) begin @(negedge clk); if (ack[1] || err[1] || !ready[1]) ok = 1'b0; end
    rst_n[1] = 1'b1;
    repeat (6) begin @(negedge clk); if (ack[1]) ok = 1'b0; end
    check("rst_no_ack", 32'(ok), 32'd1);
    access(1, 1'b0, 32'h8, 4'hF, 32'h0, "rst_rd");

    for (int i = 0; i < 80; i++) begin
      int u;
      u = (i % 4 == 3) ? 1 : 0;
      case ($urandom_range(0, 9))
        0:       a = 32'h100 + ($urandom & 32'h0FFF_FFFF);
        1:       a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        default: a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      endcase
      d = $urandom;
      access(u, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
